demux_sequencer: RTL

//   Upstream driver for the 1-to-4 demux (a,b select; o data; A..D out).

---
 rtl/demux_sequencer_if.sv | 36 +++
 rtl/demux_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/demux_sequencer_if.sv
// -----------------------------------------------------------------------------
// demux_sequencer_if
//   Bundles the word handshake, the scan control and the demux-facing outputs
//   of demux_sequencer. Clock and reset stay plain ports on the module.
//   Signals:
//     in_valid  upstream has a word on in_data
//     in_data   4-bit word, bit i goes to channel i (0=A .. 3=D)
//     hold      freeze the scan while high
//     in_ready  sequencer can accept a word (IDLE only)
//     a, b      channel select to the demux (a = MSB, b = LSB)
//     o         data bit to the demux
//     busy      high while scanning and during the done cycle
//     done      one-cycle pulse after the last channel
//   master: the upstream driver side; slave: the sequencer side.
// -----------------------------------------------------------------------------
interface demux_sequencer_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       hold;
  logic       in_ready;
  logic       a;
  logic       b;
  logic       o;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, a, b, o, busy, done
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, a, b, o, busy, done
  );
endinterface

// File: rtl/demux_sequencer.sv
// -----------------------------------------------------------------------------
// demux_sequencer
//   Upstream driver for a 1-to-4 demux. Accepts a 4-bit word over valid/ready,
//   then walks channels 0..3 in order, presenting {a,b} = channel index and
//   o = the matching word bit, holding each channel DWELL cycles. A single
//   done cycle follows channel 3, then the block returns to IDLE.
//   Parameters:
//     DWELL  cycles each channel is held (1..255)
//     CNT_W  dwell counter width, 2**CNT_W > DWELL
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous active-high reset
//     bus    demux_sequencer_if.slave (handshake, hold, select/data, status)
//   All outputs are registered: next-state logic computes the value each
//   output must show in the following cycle, so channel 0 is visible in the
//   cycle right after the accepting edge.
// -----------------------------------------------------------------------------
module demux_sequencer #(
  parameter int unsigned DWELL = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic [1:0]       ch_r, ch_s;
  logic [1:0]       ch_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       word_r, word_s;
  logic             a_r, a_s;
  logic             b_r, b_s;
  logic             o_r, o_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             ready_r, ready_s;

  assign ch_nxt_s = ch_r + 2'd1;

  // Next-state and next-output logic; every register holds unless a branch changes it.
  always_comb begin
    state_s = state_r;
    ch_s    = ch_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    a_s     = a_r;
    b_s     = b_r;
    o_s     = o_r;
    busy_s  = busy_r;
    done_s  = done_r;
    ready_s = ready_r;
    case (state_r)
      IDLE: begin
        a_s     = 1'b0;
        b_s     = 1'b0;
        o_s     = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        ready_s = 1'b1;
        if (bus.in_valid && ready_r) begin
          // Accept: channel 0 must already be on the outputs next cycle.
          word_s  = bus.in_data;
          ch_s    = 2'd0;
          cnt_s   = '0;
          state_s = SCAN;
          o_s     = bus.in_data[0];
          busy_s  = 1'b1;
          ready_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (bus.hold) begin
          // Frozen: counters and outputs keep their values.
          state_s = SCAN;
        end else if (cnt_r == LAST_CNT) begin
          cnt_s = '0;
          if (ch_r == 2'd3) begin
            state_s = DONE;
            a_s     = 1'b0;
            b_s     = 1'b0;
            o_s     = 1'b0;
            done_s  = 1'b1;
          end else begin
            ch_s = ch_nxt_s;
            a_s  = ch_nxt_s[1];
            b_s  = ch_nxt_s[0];
            o_s  = word_r[ch_nxt_s];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
        ch_s    = 2'd0;
        a_s     = 1'b0;
        b_s     = 1'b0;
        o_s     = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        ch_s    = 2'd0;
        cnt_s   = '0;
        a_s     = 1'b0;
        b_s     = 1'b0;
        o_s     = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, counters, latched word and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ch_r    <= 2'd0;
      cnt_r   <= '0;
      word_r  <= 4'd0;
      a_r     <= 1'b0;
      b_r     <= 1'b0;
      o_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      ch_r    <= ch_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
      a_r     <= a_s;
      b_r     <= b_s;
      o_r     <= o_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  assign bus.in_ready = ready_r;
  assign bus.a        = a_r;
  assign bus.b        = b_r;
  assign bus.o        = o_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule
